// File: rtl/ysyx_22041752_clint_if.sv
// CLINT slave bus: request/response handshake between the LSU and the CLINT.
// master = LSU side, slave = CLINT side.
interface ysyx_22041752_clint_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/ysyx_22041752_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a 64-bit slave port,
// producing registered timer and software interrupt levels.
module ysyx_22041752_clint #(
   parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   ysyx_22041752_clint_if.slave         bus,
   output logic                         int_t_o,
   output logic                         int_s_o
);
   localparam logic [0:0]  IDLE     = 1'b0;
   localparam logic [0:0]  RESP     = 1'b1;
   localparam logic [12:0] OFF_MSIP = 13'h0000;
   localparam logic [12:0] OFF_CMP  = 13'h0800;
   localparam logic [12:0] OFF_TIME = 13'h17FF;

   logic [0:0]  state;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;
   logic [31:0] pcnt;
   logic        tick;
   logic        accept;
   logic        wr;
   logic        in_win;
   logic        hit_msip;
   logic        hit_cmp;
   logic        hit_time;
   logic        hit;
   logic [63:0] wmask;
   logic [63:0] mtime_inc;
   logic [63:0] rdata_mux;
   logic        unused_addr;

   assign unused_addr = ^bus.req_addr[2:0];

   assign tick      = (pcnt == TICK_DIV - 1);
   assign mtime_inc = tick ? mtime + 64'd1 : mtime;

   assign bus.req_ready = (state == IDLE);
   assign accept        = bus.req_valid && (state == IDLE);
   assign wr            = accept && bus.req_wen;

   assign in_win   = (bus.req_addr[63:16] == BASE[63:16]);
   assign hit_msip = in_win && (bus.req_addr[15:3] == OFF_MSIP);
   assign hit_cmp  = in_win && (bus.req_addr[15:3] == OFF_CMP);
   assign hit_time = in_win && (bus.req_addr[15:3] == OFF_TIME);
   assign hit      = hit_msip || hit_cmp || hit_time;

   // expand byte strobes into a bit mask
   always_comb begin
      wmask = '0;
      for (int i = 0; i < 8; i++) begin
         wmask[i*8 +: 8] = {8{bus.req_wstrb[i]}};
      end
   end

   // read mux over the pre-edge register values
   always_comb begin
      rdata_mux = '0;
      unique case (1'b1)
         hit_msip: rdata_mux = {63'd0, msip};
         hit_cmp:  rdata_mux = mtimecmp;
         hit_time: rdata_mux = mtime;
         default:  rdata_mux = '0;
      endcase
   end

   // prescaler: tick on the cycle the count reaches TICK_DIV-1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt <= '0;
      end else begin
         pcnt <= tick ? '0 : pcnt + 32'd1;
      end
   end

   // timer/software registers and registered interrupt levels
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mtime    <= '0;
         mtimecmp <= '1;
         msip     <= 1'b0;
         int_t_o  <= 1'b0;
         int_s_o  <= 1'b0;
      end else begin
         if (wr && hit_time) begin
            mtime <= (mtime_inc & ~wmask) | (bus.req_wdata & wmask);
         end else begin
            mtime <= mtime_inc;
         end
         if (wr && hit_cmp) begin
            mtimecmp <= (mtimecmp & ~wmask) | (bus.req_wdata & wmask);
         end
         if (wr && hit_msip && bus.req_wstrb[0]) begin
            msip <= bus.req_wdata[0];
         end
         int_t_o <= (mtime >= mtimecmp);
         int_s_o <= msip;
      end
   end

   // two-state bus FSM: accept in IDLE, hold response in RESP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         bus.resp_valid  <= 1'b0;
         bus.resp_rdata  <= '0;
         bus.resp_err    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_rdata <= bus.req_wen ? 64'd0 : rdata_mux;
                  bus.resp_err   <= !hit;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state          <= IDLE;
                  bus.resp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_22041752_clint.sv
// Bench for ysyx_22041752_clint: two instances (TICK_DIV 1 and 4),
// scoreboard of expected bus responses.
module tb_ysyx_22041752_clint;
   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
   localparam logic [63:0] A_MSIP = BASE;
   localparam logic [63:0] A_CMP  = BASE + 64'h4000;
   localparam logic [63:0] A_TIME = BASE + 64'hBFF8;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        rv = 1'b0;
   logic        wen = 1'b0;
   logic        rr = 1'b1;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic [7:0]  strb = '0;
   logic        it0, is0, it1, is1;
   logic        o_rv, o_rq, o_err;
   logic [63:0] o_rd;

   int unsigned edges = 0;
   int unsigned rel0 = 0;
   int unsigned rel1 = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   ysyx_22041752_clint_if bus0 ();
   ysyx_22041752_clint_if bus1 ();

   assign bus0.req_valid  = rv & ~sel;
   assign bus1.req_valid  = rv & sel;
   assign bus0.req_wen    = wen;
   assign bus1.req_wen    = wen;
   assign bus0.req_addr   = addr;
   assign bus1.req_addr   = addr;
   assign bus0.req_wdata  = wdata;
   assign bus1.req_wdata  = wdata;
   assign bus0.req_wstrb  = strb;
   assign bus1.req_wstrb  = strb;
   assign bus0.resp_ready = rr;
   assign bus1.resp_ready = rr;

   assign o_rv  = sel ? bus1.resp_valid : bus0.resp_valid;
   assign o_rq  = sel ? bus1.req_ready  : bus0.req_ready;
   assign o_rd  = sel ? bus1.resp_rdata : bus0.resp_rdata;
   assign o_err = sel ? bus1.resp_err   : bus0.resp_err;

   ysyx_22041752_clint #(.BASE(BASE), .TICK_DIV(1)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .int_t_o(it0), .int_s_o(is0)
   );

   ysyx_22041752_clint #(.BASE(BASE), .TICK_DIV(4)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .int_t_o(it1), .int_s_o(is1)
   );

   // one bus transaction; expected response pushed at drive, popped on response
   task automatic xfer(input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s, input logic [63:0] er, input logic ee,
                       input bit align, input bit is_time, input logic [63:0] tbase,
                       input int unsigned torg, input int unsigned tdiv,
                       input string nm, output int unsigned acc);
      exp_t        e;
      int          n;
      int unsigned at;
      @(negedge clk);
      n = 0;
      while ((o_rq !== 1'b1 || (align && ((edges + 1 - rel1) % 4 != 0))) && n < 16) begin
         @(negedge clk);
         n++;
      end
      at = edges + 1;
      e.rdata = is_time ? tbase + 64'((at - 1 - torg) / tdiv) : er;
      e.err = ee;
      sb.push_back(e);
      rv = 1'b1; wen = w; addr = a; wdata = d; strb = s;
      @(posedge clk);
      @(negedge clk);
      rv = 1'b0;
      acc = edges;
      n = 0;
      while (o_rv !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      checks++;
      if (o_rv !== 1'b1 || o_rd !== e.rdata || o_err !== e.err) begin
         failures++;
         $display("FAIL %s: got valid=%b rdata=%h err=%b, want valid=1 rdata=%h err=%b",
                  nm, o_rv, o_rd, o_err, e.rdata, e.err);
      end
   endtask

   task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                     input logic ee, input bit align, input string nm,
                     output int unsigned acc);
      xfer(1'b1, a, d, s, 64'd0, ee, align, 1'b0, 64'd0, 0, 1, nm, acc);
   endtask

   task automatic rd(input logic [63:0] a, input logic [63:0] er, input logic ee,
                     input string nm);
      int unsigned acc;
      xfer(1'b0, a, 64'd0, 8'h00, er, ee, 1'b0, 1'b0, 64'd0, 0, 1, nm, acc);
   endtask

   task automatic rdt(input logic [63:0] tbase, input int unsigned torg,
                      input int unsigned tdiv, input string nm);
      int unsigned acc;
      xfer(1'b0, A_TIME, 64'd0, 8'h00, 64'd0, 1'b0, 1'b0, 1'b1, tbase, torg, tdiv, nm, acc);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus0.req_ready, bus0.resp_valid, bus0.resp_err, it0, is0} !== 5'b10000 ||
          {bus1.req_ready, bus1.resp_valid, bus1.resp_err, it1, is1} !== 5'b10000 ||
          bus0.resp_rdata !== 64'd0 || bus1.resp_rdata !== 64'd0) begin
         failures++;
         $display("FAIL reset_state: got d0=%b d1=%b want 10000",
                  {bus0.req_ready, bus0.resp_valid, bus0.resp_err, it0, is0},
                  {bus1.req_ready, bus1.resp_valid, bus1.resp_err, it1, is1});
      end
      reset = 1'b0;
      rel0 = edges;
      rel1 = edges;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (bus0.req_ready !== 1'b1 || it0 !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: got ready=%b int_t=%b want 1 0", bus0.req_ready, it0);
         end
      end
      rdt(64'd0, rel0, 1, "mtime_after_idle");
   endtask

   task automatic test_timer;
      int unsigned acc;
      int          n;
      wr(A_CMP, 64'd20, 8'hFF, 1'b0, 1'b0, "cmp20_wr", acc);
      checks++;
      if (it0 !== 1'b0) begin
         failures++;
         $display("FAIL cmp20_early: got int_t=%b want 0", it0);
      end
      n = 0;
      while (it0 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (edges !== rel0 + 21) begin
         failures++;
         $display("FAIL int_t_rise: got edge %0d want %0d", edges - rel0, 21);
      end
      wr(A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 1'b0, "cmp_max_wr", acc);
      checks++;
      if (it0 !== 1'b1) begin
         failures++;
         $display("FAIL int_t_lag: got %b want 1", it0);
      end
      @(negedge clk);
      checks++;
      if (it0 !== 1'b0) begin
         failures++;
         $display("FAIL int_t_clear: got %b want 0", it0);
      end
      rd(A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "cmp_readback");
   endtask

   task automatic test_wrap;
      int unsigned acc;
      int unsigned am;
      wr(A_CMP, 64'd0, 8'hFF, 1'b0, 1'b0, "cmp0_wr", acc);
      wr(A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b0, 1'b0, "mtime_wr", am);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (it0 !== 1'b1) begin
            failures++;
            $display("FAIL wrap_int_t: cycle %0d got %b want 1", i, it0);
         end
      end
      rdt(64'hFFFF_FFFF_FFFF_FFFE, am, 1, "mtime_wrapped");
   endtask

   task automatic test_msip;
      int unsigned acc;
      wr(A_MSIP, 64'd1, 8'h01, 1'b0, 1'b0, "msip_set", acc);
      checks++;
      if (is0 !== 1'b0) begin
         failures++;
         $display("FAIL int_s_lag: got %b want 0", is0);
      end
      @(negedge clk);
      checks++;
      if (is0 !== 1'b1) begin
         failures++;
         $display("FAIL int_s_rise: got %b want 1", is0);
      end
      rd(A_MSIP, 64'd1, 1'b0, "msip_read1");
      wr(A_MSIP, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFE, 1'b0, 1'b0, "msip_nostrb", acc);
      rd(A_MSIP, 64'd1, 1'b0, "msip_kept");
      wr(A_MSIP, 64'd0, 8'h01, 1'b0, 1'b0, "msip_clr", acc);
      @(negedge clk);
      checks++;
      if (is0 !== 1'b0) begin
         failures++;
         $display("FAIL int_s_clear: got %b want 0", is0);
      end
      rd(A_MSIP, 64'd0, 1'b0, "msip_read0");
   endtask

   task automatic test_err_hold;
      int unsigned acc;
      exp_t        e;
      @(negedge clk);
      e.rdata = 64'd0;
      e.err = 1'b1;
      sb.push_back(e);
      rr = 1'b0;
      rv = 1'b1; wen = 1'b0; addr = BASE + 64'h100; wdata = '0; strb = '0;
      @(posedge clk);
      @(negedge clk);
      rv = 1'b1; wen = 1'b1; addr = A_MSIP; wdata = 64'd1; strb = 8'h01;
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (o_rv !== 1'b1 || o_rd !== e.rdata || o_err !== e.err || o_rq !== 1'b0) begin
            failures++;
            $display("FAIL err_hold: cycle %0d got v=%b rd=%h err=%b rdy=%b want 1 %h %b 0",
                     i, o_rv, o_rd, o_err, o_rq, e.rdata, e.err);
         end
         @(negedge clk);
      end
      rr = 1'b1;
      rv = 1'b0;
      @(negedge clk);
      checks++;
      if (o_rv !== 1'b0) begin
         failures++;
         $display("FAIL err_release: got %b want 0", o_rv);
      end
      rd(A_MSIP, 64'd0, 1'b0, "ignored_req");
      rd(BASE + 64'h1_0000, 64'd0, 1'b1, "out_of_window");
      wr(BASE + 64'h8, 64'hDEAD, 8'hFF, 1'b1, 1'b0, "unmapped_wr", acc);
   endtask

   task automatic test_div4_reset;
      int unsigned w1;
      int unsigned w2;
      logic [63:0] old;
      logic [63:0] want;
      sel = 1'b1;
      rdt(64'd0, rel1, 4, "div4_read_a");
      repeat (3) @(negedge clk);
      rdt(64'd0, rel1, 4, "div4_read_b");
      wr(A_TIME, 64'h1FF, 8'hFF, 1'b0, 1'b1, "div4_full_wr", w1);
      wr(A_TIME, 64'h1234_5678_9ABC_DEA5, 8'h01, 1'b0, 1'b1, "div4_byte_wr", w2);
      old = 64'h1FF + 64'((w2 - 1 - w1) / 4);
      want = ((old + 64'd1) & ~64'hFF) | 64'hA5;
      rdt(want, w2, 4, "div4_tick_merge");
      rr = 1'b0;
      @(negedge clk);
      rv = 1'b1; wen = 1'b0; addr = A_TIME;
      @(posedge clk);
      @(negedge clk);
      rv = 1'b0;
      checks++;
      if (o_rv !== 1'b1) begin
         failures++;
         $display("FAIL mid_resp_valid: got %b want 1", o_rv);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (o_rv !== 1'b0 || o_rq !== 1'b1 || o_err !== 1'b0 || o_rd !== 64'd0 || it1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_resp: got v=%b rdy=%b err=%b rd=%h it=%b want 0 1 0 0 0",
                  o_rv, o_rq, o_err, o_rd, it1);
      end
      @(negedge clk);
      reset = 1'b0;
      rr = 1'b1;
      rel1 = edges;
      rdt(64'd0, rel1, 4, "div4_after_reset");
   endtask

   initial begin
      test_reset();
      test_timer();
      test_wrap();
      test_msip();
      test_err_hold();
      test_div4_reset();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left: got %0d want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
